// File: rtl/bcd_seg_scan_if.sv
// rtl/bcd_seg_scan_if.sv - data/display bundle for the two-digit BCD scanner
//
// Groups the value-capture inputs and the multiplexed display outputs.
//   bcd_data   [7:0]  packed BCD, [7:4] tens, [3:0] units
//   data_valid        capture strobe for bcd_data
//   blank_lz          1 = suppress a leading tens zero
//   seg        [6:0]  active-low segments {g,f,e,d,c,b,a}
//   an         [1:0]  active-low digit enables, an[0] units, an[1] tens
//   frame_done        one-cycle pulse in the last cycle of each frame
// master: the data source / display consumer. slave: the scanner.

interface bcd_seg_scan_if;
  logic [7:0] bcd_data;
  logic       data_valid;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_done;

  modport master (
    output bcd_data,
    output data_valid,
    output blank_lz,
    input  seg,
    input  an,
    input  frame_done
  );

  modport slave (
    input  bcd_data,
    input  data_valid,
    input  blank_lz,
    output seg,
    output an,
    output frame_done
  );
endinterface

// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - two-digit multiplexed 7-segment BCD display scanner
//
// Scans a two-digit packed BCD value onto a common 7-segment display.
// Each digit owns SCAN_DIV clock cycles; the first BLANK_CYC cycles of every
// digit period keep both anodes off to avoid ghosting.
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : bcd_seg_scan_if.slave (bcd_data, data_valid, blank_lz in;
//            seg, an, frame_done out, all outputs registered)
// Supported settings: BLANK_CYC >= 1, SCAN_DIV >= BLANK_CYC + 2.

module bcd_seg_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd_seg_scan_if.slave bus
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

  typedef enum logic {
    DIG0 = 1'b0,
    DIG1 = 1'b1
  } dig_t;

  // Current state
  dig_t          state;
  logic [CW-1:0] cnt;
  logic          started;
  logic [7:0]    shadow;
  logic [7:0]    disp;

  // Registered outputs
  logic [6:0]    seg_q;
  logic [1:0]    an_q;
  logic          fd_q;

  // Next-state values
  dig_t          nxt_state;
  logic [CW-1:0] nxt_cnt;
  logic [7:0]    nxt_disp;
  logic [6:0]    nxt_seg;
  logic [1:0]    nxt_an;
  logic          nxt_fd;
  logic          wrap;
  logic          boundary;
  logic          tens_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;   // non-BCD nibble shows a dash
    endcase
    return s;
  endfunction

  // Outputs are computed from the next-state values so that the registered
  // seg/an/frame_done line up exactly with the state they describe. The
  // first edge after reset release only arms the scanner (started), so the
  // first visible digit period begins with prescaler 0 in that cycle.
  always_comb begin
    wrap     = started && (cnt == CNT_LAST);
    boundary = wrap && (state == DIG1);

    nxt_cnt   = cnt;
    nxt_state = state;
    if (started) begin
      nxt_cnt = wrap ? '0 : cnt + 1'b1;
    end
    if (wrap) begin
      nxt_state = (state == DIG0) ? DIG1 : DIG0;
    end

    // A strobe landing on the boundary cycle wins over the shadow copy,
    // so the new value shows in the very next frame.
    nxt_disp = disp;
    if (boundary) begin
      nxt_disp = bus.data_valid ? bus.bcd_data : shadow;
    end

    tens_blank = bus.blank_lz && (nxt_disp[7:4] == 4'd0);

    nxt_an  = AN_OFF;
    nxt_seg = SEG_OFF;
    if (nxt_cnt >= CNT_BLANK) begin
      if (nxt_state == DIG0) begin
        nxt_an  = AN_UNITS;
        nxt_seg = seg_decode(nxt_disp[3:0]);
      end else if (!tens_blank) begin
        nxt_an  = AN_TENS;
        nxt_seg = seg_decode(nxt_disp[7:4]);
      end
    end

    nxt_fd = (nxt_state == DIG1) && (nxt_cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DIG0;
      cnt     <= '0;
      started <= 1'b0;
      shadow  <= 8'h00;
      disp    <= 8'h00;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      fd_q    <= 1'b0;
    end else begin
      started <= 1'b1;
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      disp    <= nxt_disp;
      if (bus.data_valid) begin
        shadow <= bus.bcd_data;
      end
      seg_q   <= nxt_seg;
      an_q    <= nxt_an;
      fd_q    <= nxt_fd;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb/tb_bcd_seg_scan.sv - scoreboard bench for bcd_seg_scan (SCAN_DIV=8, BLANK_CYC=2)

module tb_bcd_seg_scan;

  logic clk;
  logic rst_n;

  bcd_seg_scan_if u_if ();

  bcd_seg_scan #(
    .SCAN_DIV (8),
    .BLANK_CYC(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if.slave)
  );

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   out_idx = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: the display presents an output every cycle; compare away from
  // the active edge whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (u_if.an !== e.an || u_if.seg !== e.seg || u_if.frame_done !== e.fd) begin
          errors++;
          $display("FAIL out[%0d]: got an=%b seg=%h fd=%b, expected an=%b seg=%h fd=%b",
                   out_idx, u_if.an, u_if.seg, u_if.frame_done, e.an, e.seg, e.fd);
        end
        out_idx++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic push_reset(input int n);
    exp_t e;
    e.an  = 2'b11;
    e.seg = 7'h7F;
    e.fd  = 1'b0;
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  // Called at posedge+1 of the first cycle of a frame. Pushes the expected
  // outputs for the first n_cyc cycles, then runs them, optionally strobing
  // drv_val during frame cycle drv_i. t_seg = 7F means the tens digit is
  // expected blanked (an stays 11). Returns at posedge+1 of cycle n_cyc.
  task automatic run_frame(input logic [6:0] u_seg, input logic [6:0] t_seg,
                           input logic lz, input int n_cyc,
                           input int drv_i, input logic [7:0] drv_val);
    exp_t e;
    u_if.blank_lz = lz;
    for (int i = 0; i < n_cyc; i++) begin
      if ((i % 8) < 2) begin
        e.an = 2'b11; e.seg = 7'h7F;
      end else if (i < 8) begin
        e.an = 2'b10; e.seg = u_seg;
      end else if (t_seg == 7'h7F) begin
        e.an = 2'b11; e.seg = 7'h7F;
      end else begin
        e.an = 2'b01; e.seg = t_seg;
      end
      e.fd = (i == 15);
      exp_q.push_back(e);
    end
    for (int i = 0; i < n_cyc; i++) begin
      if (i == drv_i) begin
        u_if.data_valid = 1'b1;
        u_if.bcd_data   = drv_val;
      end
      wait_edge();
      u_if.data_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    u_if.bcd_data   = 8'h00;
    u_if.data_valid = 1'b0;
    u_if.blank_lz   = 1'b0;
    push_reset(3);
    #32;
    rst_n = 1'b1;
    wait_edge();

    // Idle frames showing 00
    run_frame(7'h40, 7'h40, 1'b0, 16, -1, 8'h00);
    run_frame(7'h40, 7'h40, 1'b0, 16, -1, 8'h00);
    // 47 captured mid-DIG0: current frame still 00
    run_frame(7'h40, 7'h40, 1'b0, 16, 3, 8'h47);
    run_frame(7'h78, 7'h19, 1'b0, 16, -1, 8'h00);
    // 05 captured with leading-zero blanking on
    run_frame(7'h78, 7'h19, 1'b1, 16, 3, 8'h05);
    run_frame(7'h12, 7'h7F, 1'b1, 16, -1, 8'h00);
    // Blanking off: tens zero shown; capture 9A
    run_frame(7'h12, 7'h40, 1'b0, 16, 3, 8'h9A);
    // 9A: units dash; 90 strobed exactly on the frame boundary
    run_frame(7'h3F, 7'h10, 1'b0, 16, 15, 8'h90);
    // 90 with blanking on: units zero is never blanked
    run_frame(7'h40, 7'h10, 1'b1, 16, -1, 8'h00);
    // Capture 55, then reset at prescaler 5 of DIG1
    run_frame(7'h40, 7'h10, 1'b0, 13, 12, 8'h55);
    rst_n = 1'b0;
    push_reset(2);
    wait_edge();
    wait_edge();
    rst_n = 1'b1;
    wait_edge();
    // Restart from DIG0 with display 00; captured 55 discarded
    run_frame(7'h40, 7'h40, 1'b0, 16, -1, 8'h00);
    run_frame(7'h40, 7'h40, 1'b0, 16, -1, 8'h00);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
